// File: rtl/wb_skid_buffer.sv
// wb_skid_buffer: writeback-stage valid/ready buffer with a 2-entry skid, flush and per-lane write mask.
// Optional same-cycle bypass from an empty buffer is enabled by defining WB_BYPASS_EN.
`default_nettype none

module wb_skid_buffer #(
    parameter int LANES = 8,
    parameter int N     = 20,
    parameter int RA_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   register1,
    input  logic [LANES*N-1:0]   ALUOut,
    input  logic [RA_W-1:0]      WA3,
    input  logic                 RegWrite,
    input  logic                 MemtoReg,
    input  logic [LANES-1:0]     lane_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   q1,
    output logic [LANES*N-1:0]   ALUOutO,
    output logic [RA_W-1:0]      WA3O,
    output logic                 RegWriteO,
    output logic                 MemtoRegO,
    output logic [LANES-1:0]     lane_maskO
);

    localparam int PW = 2*LANES*N + RA_W + 2 + LANES;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_main;
    logic [PW-1:0]   r_skid;
    logic            r_in_ready;
    logic [PW-1:0]   w_in_pl;
    logic [PW-1:0]   w_head;
    logic            w_bypass;
    logic            w_out_valid;
    logic            w_acc;
    logic            w_drn;
    logic            w_load_main;
    logic            w_load_skid;
    logic            w_skid_to_main;

    assign w_in_pl = {register1, ALUOut, WA3, RegWrite, MemtoReg, lane_mask};

`ifdef WB_BYPASS_EN
    // Reset is included so the bypass cannot present an entry while the buffer is held in reset.
    assign w_bypass = (r_state == S_EMPTY) & in_valid & ~flush & ~reset;
    assign w_head   = w_bypass ? w_in_pl : r_main;
`else
    assign w_bypass = 1'b0;
    assign w_head   = r_main;
`endif

    assign w_out_valid = (r_state != S_EMPTY) | w_bypass;
    assign w_acc       = in_valid & r_in_ready;
    assign w_drn       = w_out_valid & out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            S_EMPTY: begin
                // A bypassed entry that is consumed immediately is never stored.
                if (w_acc && !(w_bypass && out_ready)) begin
                    w_load_main = 1'b1;
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_acc && w_drn) begin
                    w_load_main = 1'b1;
                end else if (w_acc) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = S_TWO;
                end else if (w_drn) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_drn) begin
                    w_skid_to_main = 1'b1;
                    w_state_nxt    = S_ONE;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        if (flush) begin
            w_load_main    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_main = 1'b0;
            w_state_nxt    = S_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
            if (w_load_main) begin
                r_main <= w_in_pl;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_pl;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = w_out_valid;
    assign q1         = w_head[PW-1 -: LANES*N];
    assign ALUOutO    = w_head[PW-1-LANES*N -: LANES*N];
    assign WA3O       = w_head[LANES+2 +: RA_W];
    assign RegWriteO  = w_head[LANES+1] & w_out_valid;
    assign MemtoRegO  = w_head[LANES];
    assign lane_maskO = w_head[LANES-1:0] & {LANES{w_out_valid}};

endmodule

`default_nettype wire

// File: tb/tb_wb_skid_buffer.sv
// tb_wb_skid_buffer: directed self-checking bench for wb_skid_buffer.
`default_nettype none

module tb_wb_skid_buffer;

    localparam int LANES = 8;
    localparam int N     = 20;
    localparam int RA_W  = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [LANES*N-1:0]  register1 = '0;
    logic [LANES*N-1:0]  ALUOut = '0;
    logic [RA_W-1:0]     WA3 = '0;
    logic                RegWrite = 1'b0;
    logic                MemtoReg = 1'b0;
    logic [LANES-1:0]    lane_mask = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [LANES*N-1:0]  q1;
    logic [LANES*N-1:0]  ALUOutO;
    logic [RA_W-1:0]     WA3O;
    logic                RegWriteO;
    logic                MemtoRegO;
    logic [LANES-1:0]    lane_maskO;

    int n_checks = 0;
    int n_pass   = 0;

    wb_skid_buffer #(.LANES(LANES), .N(N), .RA_W(RA_W)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .register1  (register1),
        .ALUOut     (ALUOut),
        .WA3        (WA3),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .lane_mask  (lane_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q1         (q1),
        .ALUOutO    (ALUOutO),
        .WA3O       (WA3O),
        .RegWriteO  (RegWriteO),
        .MemtoRegO  (MemtoRegO),
        .lane_maskO (lane_maskO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane 0 of ALUOut carries val, lane 0 of register1 carries val + 100; other lanes replicate.
    task automatic set_in(input logic v, input logic [19:0] val, input logic [3:0] wa,
                          input logic rw, input logic mr, input logic [7:0] mask);
        logic [19:0] r1;
        r1        = val + 20'd100;
        in_valid  = v;
        ALUOut    = {LANES{val}};
        register1 = {LANES{r1}};
        WA3       = wa;
        RegWrite  = rw;
        MemtoReg  = mr;
        lane_mask = mask;
    endtask

    initial begin
        // Reset held with an entry offered: nothing may appear.
        set_in(1'b1, 20'd7, 4'd7, 1'b1, 1'b0, 8'hFF);
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_q1",        q1, 0);
        chk("rst_aluo",      ALUOutO, 0);
        chk("rst_wa3o",      WA3O, 0);
        chk("rst_regwrite",  RegWriteO, 0);
        chk("rst_lanemask",  lane_maskO, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;

`ifndef WB_BYPASS_EN
        tick();
        chk("first_valid", out_valid, 1);
        chk("first_alu",   ALUOutO[19:0], 7);
        chk("first_q1",    q1[19:0], 107);
        set_in(1'b0, 20'd0, 4'd0, 1'b0, 1'b0, 8'h00);
        out_ready = 1'b1;
        tick();
        chk("first_drained", out_valid, 0);

        // Back-to-back stream with the consumer always ready.
        for (int k = 1; k <= 10; k++) begin
            set_in(1'b1, k[19:0], 4'd1, 1'b1, 1'b0, 8'h0F);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data",  ALUOutO[19:0], k);
            chk("stream_ready", in_ready, 1);
        end
        set_in(1'b0, 20'd0, 4'd0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("stream_end", out_valid, 0);

        // Back-pressure: A in main, B into skid, C held upstream.
        out_ready = 1'b0;
        set_in(1'b1, 20'd21, 4'd3, 1'b1, 1'b0, 8'hFF);
        tick();
        chk("bp_a_wa3",  WA3O, 3);
        chk("bp_a_rdy",  in_ready, 1);
        set_in(1'b1, 20'd22, 4'd5, 1'b1, 1'b0, 8'hFF);
        tick();
        chk("bp_b_wa3",  WA3O, 3);
        chk("bp_b_rdy",  in_ready, 0);
        set_in(1'b1, 20'd23, 4'd6, 1'b1, 1'b0, 8'hFF);
        tick();
        chk("bp_hold_wa3", WA3O, 3);
        chk("bp_hold_alu", ALUOutO[19:0], 21);
        chk("bp_hold_rdy", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b",   WA3O, 5);
        chk("bp_out_b_d", ALUOutO[19:0], 22);
        chk("bp_rdy_back", in_ready, 1);
        tick();
        chk("bp_out_c",   WA3O, 6);
        chk("bp_out_c_d", ALUOutO[19:0], 23);
        set_in(1'b0, 20'd0, 4'd0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("bp_empty", out_valid, 0);

        // Flush while full with another entry offered.
        out_ready = 1'b0;
        set_in(1'b1, 20'd31, 4'd1, 1'b1, 1'b0, 8'hFF);
        tick();
        set_in(1'b1, 20'd32, 4'd2, 1'b1, 1'b0, 8'hFF);
        tick();
        chk("fl_full", in_ready, 0);
        set_in(1'b1, 20'd33, 4'd9, 1'b1, 1'b0, 8'hFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid",    out_valid, 0);
        chk("fl_regwrite", RegWriteO, 0);
        chk("fl_mask",     lane_maskO, 0);
        chk("fl_rdy",      in_ready, 1);
        set_in(1'b0, 20'd0, 4'd0, 1'b0, 1'b0, 8'h00);
        out_ready = 1'b1;
        tick();
        chk("fl_gone", out_valid, 0);

        // Lane mask and control bits, gated once drained.
        out_ready = 1'b0;
        set_in(1'b1, 20'd41, 4'd4, 1'b1, 1'b1, 8'b1010_0101);
        tick();
        set_in(1'b0, 20'd0, 4'd0, 1'b0, 1'b0, 8'h00);
        chk("mk_mask",  lane_maskO, 8'hA5);
        chk("mk_rw",    RegWriteO, 1);
        chk("mk_m2r",   MemtoRegO, 1);
        chk("mk_q1",    q1[19:0], 141);
        out_ready = 1'b1;
        tick();
        chk("mk_rw_off",   RegWriteO, 0);
        chk("mk_mask_off", lane_maskO, 0);

        // Reset mid-operation, applied away from the clock edge.
        out_ready = 1'b0;
        set_in(1'b1, 20'd51, 4'd8, 1'b1, 1'b0, 8'hFF);
        tick();
        tick();
        chk("mr_full", in_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_rdy",   in_ready, 1);
        chk("mr_alu",   ALUOutO, 0);
        @(negedge clk);
        reset = 1'b0;
`else
        // Same-cycle bypass from an empty buffer.
        set_in(1'b1, 20'h55, 4'd2, 1'b1, 1'b0, 8'h3C);
        out_ready = 1'b1;
        #1;
        chk("bp_now_valid", out_valid, 1);
        chk("bp_now_alu",   ALUOutO[19:0], 20'h55);
        chk("bp_now_wa3",   WA3O, 2);
        chk("bp_now_mask",  lane_maskO, 8'h3C);
        tick();
        set_in(1'b0, 20'd0, 4'd0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("bp_not_stored", out_valid, 0);
        set_in(1'b1, 20'h66, 4'd3, 1'b1, 1'b0, 8'hFF);
        flush = 1'b1;
        #1;
        chk("bp_flush", out_valid, 0);
        flush = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("bp_stall_valid", out_valid, 1);
        tick();
        set_in(1'b0, 20'd0, 4'd0, 1'b0, 1'b0, 8'h00);
        chk("bp_stored", ALUOutO[19:0], 20'h66);
        chk("bp_stored_v", out_valid, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_skid_buffer.md
Name: wb_skid_buffer

Overview:
- Parametrised writeback-stage pipeline buffer for the vector datapath, placed between the memory stage and the register-file write port.
- Carries per-lane load data, ALU results, the destination register and control bits.
- Adds a valid/ready handshake, a 2-entry skid so back-pressure never drops an instruction, flush support, and a per-lane write mask.
- Successor to the fixed 8x20-bit, load-enabled writeback register.

Parameters:
- LANES, 8, number of vector lanes.
- N, 20, bits per lane element.
- RA_W, 4, destination register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  buffer can accept an entry this cycle.
- register1  in  LANES*N  per-lane memory read data.
- ALUOut  in  LANES*N  per-lane ALU result.
- WA3  in  RA_W  destination register.
- RegWrite  in  1  register write enable.
- MemtoReg  in  1  select memory data for writeback.
- lane_mask  in  LANES  per-lane write enable.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head this cycle.
- q1  out  LANES*N  head register1.
- ALUOutO  out  LANES*N  head ALUOut.
- WA3O  out  RA_W  head WA3.
- RegWriteO  out  1  head RegWrite AND out_valid.
- MemtoRegO  out  1  head MemtoReg.
- lane_maskO  out  LANES  head lane_mask AND {LANES{out_valid}}.

Behaviour:
- Reset (async, active-high): both entries invalid; all payload registers 0; out_valid=0, RegWriteO=0, lane_maskO=0, in_ready=1.
- Storage: a main entry (drives the outputs) and a skid entry. Occupancy state is EMPTY, ONE or TWO.
- Definitions: acc = in_valid & in_ready; drn = out_valid & out_ready.
- in_ready is registered and equals !skid_valid, i.e. 1 in EMPTY and ONE, 0 in TWO.
- EMPTY:
  - acc -> input loads into main; go to ONE.
- ONE:
  - acc & drn -> input loads into main; stay ONE.
  - acc & !drn -> input loads into skid; go to TWO.
  - !acc & drn -> go to EMPTY.
- TWO:
  - drn -> skid moves to main; go to ONE.
  - No accept is possible (in_ready=0).
- Ordering: strictly FIFO. The skid entry is never presented before main.
- Latency: 1 cycle from acceptance to out_valid. Throughput is 1 entry/cycle while out_ready is held at 1.
- Output stability: while out_valid=1 and out_ready=0, every output is held stable.
- flush:
  - At the next edge both valids clear and the state goes to EMPTY.
  - flush overrides a simultaneous acc and drn: the entry at the input is discarded.
  - Payload registers keep their values; RegWriteO and lane_maskO read 0 because they are gated by out_valid.
- Reset asserted mid-operation clears everything immediately; no partial transfer completes.
- Payload is passed through with no arithmetic and no width conversion; fields are packed lane 0 in the LSBs.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - When the state is EMPTY and in_valid=1, the input drives the outputs combinationally that same cycle, with out_valid=1.
  - If out_ready=1 the entry is consumed with zero latency and is not stored.
  - If out_ready=0 it is stored into main as in the normal acceptance path.
  - flush=1 suppresses the bypass (out_valid=0).
- Undefined: fixed 1-cycle latency as described above; no combinational path from the inputs to the outputs.

Test Plan:
- Reset with in_valid=1 held -> out_valid=0, all outputs 0, in_ready=1. After release, one entry accepted -> out_valid=1 on the next cycle.
- Stream 10 entries, ALUOut lane0 = 1..10, with out_ready=1 -> outputs 1..10 in order on consecutive cycles, no gaps, in_ready stays 1.
- Accept A (WA3=3), drop out_ready for 2 cycles while offering B (WA3=5) and C -> B goes to skid, in_ready=0, C is held upstream. Raise out_ready -> A, B, C appear in order.
- In state TWO assert flush with in_valid=1 -> next cycle out_valid=0, RegWriteO=0, lane_maskO=0, in_ready=1; the offered entry never appears.
- lane_mask=8'b1010_0101 with RegWrite=1, MemtoReg=1 -> lane_maskO=8'hA5, RegWriteO=1, MemtoRegO=1 while valid; 0 on RegWriteO and lane_maskO once drained.
- WB_BYPASS_EN defined, EMPTY, in_valid=1, out_ready=1 -> out_valid=1 in the same cycle, out payload equals the input, state stays EMPTY.
